// File: rtl/sound_pkg.sv
// Shared types and helpers for the polyphonic sample player.
package sound_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_READ,
        M_SUM,
        M_WRITE
    } mix_state_e;

    typedef enum logic {
        IDLE,
        PLAY
    } voice_state_e;

    // Clamp a signed value into the range of an out_w-bit signed number.
    // The caller truncates the result to out_w bits; out_w must be 2..31.
    function automatic logic signed [31:0] sat_resize(input logic signed [31:0] v,
                                                      input int unsigned out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/poly_sound_if.sv
// Codec FIFO write handshake: room indication, write strobe and sample.
interface poly_sound_if #(
    parameter int unsigned OUT_W = 10
);
    logic                    audio_out_allowed;
    logic                    write_audio_out;
    logic signed [OUT_W-1:0] audio_out;

    modport master (
        input  audio_out_allowed,
        output write_audio_out,
        output audio_out
    );

    modport slave (
        output audio_out_allowed,
        input  write_audio_out,
        input  audio_out
    );
endinterface

// File: rtl/voice_ctrl.sv
// One voice: play edge detect, deferred trigger, latched end address and
// the ROM address counter that the shared mixer advances once per sample.
module voice_ctrl
    import sound_pkg::*;
#(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_play,
    input  logic              i_loop_en,
    input  logic [ADDR_W-1:0] i_address_max,
    input  logic              i_mix_idle,
    input  logic              i_mix_sum,
    input  logic              i_mix_write,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_active,
    output logic              o_up
);

    voice_state_e      r_state;
    logic              r_play_d;
    logic              r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_max;
    logic              r_up;

    logic              w_edge;
    logic              w_at_end;

    assign w_edge   = i_play & ~r_play_d;
    assign w_at_end = (r_addr == r_max);

    assign o_rom_addr = r_addr;
    assign o_active   = (r_state == PLAY);
    assign o_up       = r_up;

    // Voice FSM; triggers outside M_IDLE wait for M_WRITE and replace the advance.
    // up is registered during M_SUM so it lines up with the write strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_play_d  <= 1'b0;
            r_pending <= 1'b0;
            r_addr    <= '0;
            r_max     <= '0;
            r_up      <= 1'b0;
        end else begin
            r_play_d <= i_play;
            r_up     <= i_mix_sum && (r_state == PLAY) && w_at_end;
            if (i_mix_idle) begin
                r_pending <= 1'b0;
                if (w_edge) begin
                    r_addr  <= '0;
                    r_max   <= i_address_max;
                    r_state <= PLAY;
                end
            end else if (i_mix_write) begin
                r_pending <= 1'b0;
                if (w_edge || r_pending) begin
                    r_addr  <= '0;
                    r_max   <= i_address_max;
                    r_state <= PLAY;
                end else if (r_state == PLAY) begin
                    if (!w_at_end) begin
                        r_addr <= r_addr + 1'b1;
                    end else begin
                        r_addr <= '0;
                        if (!i_loop_en) begin
                            r_state <= IDLE;
                        end
                    end
                end
            end else if (w_edge) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_sound.sv
// Polyphonic sample player: NUM_VOICES voice controllers feeding a shared
// four-phase mixer that writes one saturated sample per codec handshake.
module poly_sound
    import sound_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 10,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned OUT_W      = 10
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [NUM_VOICES-1:0]          play,
    input  logic [NUM_VOICES-1:0]          loop_en,
    input  logic [NUM_VOICES*ADDR_W-1:0]   address_max,
    output logic [NUM_VOICES*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] rom_q,
    output logic                           clear_buffer,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES-1:0]          up,
    poly_sound_if.master                   aud
);

    localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

    mix_state_e              r_mstate;
    logic signed [OUT_W-1:0] r_audio_out;
    logic                    r_write;

    logic                    w_mix_idle;
    logic                    w_mix_sum;
    logic                    w_mix_write;
    logic signed [SUM_W-1:0] w_sum;

    assign w_mix_idle  = (r_mstate == M_IDLE);
    assign w_mix_sum   = (r_mstate == M_SUM);
    assign w_mix_write = (r_mstate == M_WRITE);

    assign aud.audio_out       = r_audio_out;
    assign aud.write_audio_out = r_write;
    assign clear_buffer        = ~|voice_active;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        voice_ctrl #(
            .ADDR_W(ADDR_W)
        ) u_voice (
            .clock        (clock),
            .resetn       (resetn),
            .i_play       (play[g]),
            .i_loop_en    (loop_en[g]),
            .i_address_max(address_max[g*ADDR_W +: ADDR_W]),
            .i_mix_idle   (w_mix_idle),
            .i_mix_sum    (w_mix_sum),
            .i_mix_write  (w_mix_write),
            .o_rom_addr   (rom_addr[g*ADDR_W +: ADDR_W]),
            .o_active     (voice_active[g]),
            .o_up         (up[g])
        );
    end

    // Sign-extended sum of the samples of all active voices.
    always_comb begin
        w_sum = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v]) begin
                w_sum = w_sum + SUM_W'($signed(rom_q[v*SAMPLE_W +: SAMPLE_W]));
            end
        end
    end

    // Mixer FSM: accept in M_IDLE, wait for ROM, register the clamped sum, strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mstate    <= M_IDLE;
            r_audio_out <= '0;
            r_write     <= 1'b0;
        end else begin
            case (r_mstate)
                M_IDLE: begin
                    r_write <= 1'b0;
                    if ((|voice_active) && aud.audio_out_allowed) begin
                        r_mstate <= M_READ;
                    end
                end
                M_READ: begin
                    r_mstate <= M_SUM;
                end
                M_SUM: begin
                    r_audio_out <= OUT_W'(sat_resize(32'(w_sum), OUT_W));
                    r_write     <= 1'b1;
                    r_mstate    <= M_WRITE;
                end
                M_WRITE: begin
                    r_write  <= 1'b0;
                    r_mstate <= M_IDLE;
                end
                default: begin
                    r_write  <= 1'b0;
                    r_mstate <= M_IDLE;
                end
            endcase
        end
    end

endmodule
